// File: rtl/module_control_teclado_if.sv
// Key handshake bundle between the keypad scanner and its consumer.
// The master side produces debounced key codes. The slave side accepts them.
interface module_control_teclado_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_pressed;
  logic       key_lost;

  modport master (
    output key_code,
    output key_valid,
    output key_pressed,
    output key_lost,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_pressed,
    input  key_lost,
    output key_ready
  );
endinterface

// File: rtl/module_control_teclado.sv
// 4x4 keypad scanner: strobes columns, debounces press/release on scan ticks, and
// hands out each accepted key once over a valid/ready handshake.
module module_control_teclado #(
  parameter int unsigned SCAN_DIV   = 27000,
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      row_i,
  output logic [3:0]                      col_o,
  module_control_teclado_if.master        key
);

  localparam int unsigned    DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]     DebN   = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {StScan, StDebounce, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      row_meta_q, rs_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      col_q, col_d;
  logic [1:0]      r_q, r_d;
  logic [3:0]      deb_cnt_q, deb_cnt_d;
  logic [3:0]      rel_cnt_q, rel_cnt_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            lost_q, lost_d;

  logic       tick, hit, all_high, accept;
  logic [1:0] hit_row;

  assign tick     = (div_q == DivMax);
  assign all_high = (rs_q == 4'hf);

  // A hit is exactly one row low; multi-row (ghosting) patterns are treated as idle.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    unique case (rs_q)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    r_d       = r_q;
    deb_cnt_d = deb_cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept    = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            r_d       = hit_row;
            deb_cnt_d = 4'd1;
            if (DEBOUNCE_N == 1) begin
              accept    = 1'b1;
              state_d   = StHold;
              rel_cnt_d = 4'd0;
            end else begin
              state_d = StDebounce;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        StDebounce: begin
          if (hit && (hit_row == r_q)) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_d == DebN) begin
              accept    = 1'b1;
              state_d   = StHold;
              rel_cnt_d = 4'd0;
            end
          end else begin
            state_d = StScan;
            idx_d   = idx_q + 2'd1;
          end
        end
        StHold: begin
          if (all_high) begin
            rel_cnt_d = rel_cnt_q + 4'd1;
            if (rel_cnt_d == DebN) begin
              state_d = StScan;
              idx_d   = idx_q + 2'd1;
            end
          end else begin
            rel_cnt_d = 4'd0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  // Consume is applied before accept so a same-cycle handoff never drops the new key.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q & ~key.key_ready;
    lost_d  = 1'b0;
    if (accept) begin
      if (valid_d) begin
        lost_d = 1'b1;
      end else begin
        code_d  = {r_d, idx_q};
        valid_d = 1'b1;
      end
    end
  end

  assign div_d = tick ? '0 : div_q + DivW'(1);
  assign col_d = ~(4'b0001 << idx_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hf;
      rs_q       <= 4'hf;
      state_q    <= StScan;
      div_q      <= '0;
      idx_q      <= 2'd0;
      col_q      <= 4'b1110;
      r_q        <= 2'd0;
      deb_cnt_q  <= 4'd0;
      rel_cnt_q  <= 4'd0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      row_meta_q <= row_i;
      rs_q       <= row_meta_q;
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      r_q        <= r_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      lost_q     <= lost_d;
    end
  end

  assign col_o           = col_q;
  assign key.key_code    = code_q;
  assign key.key_valid   = valid_q;
  assign key.key_lost    = lost_q;
  assign key.key_pressed = (state_q == StHold);

endmodule

// File: tb/tb_module_control_teclado.sv
// Randomized and directed bench for the keypad scanner, checked every cycle against a
// tick-level behavioural model of the scan/debounce/handshake rules.
module tb_module_control_teclado;
  localparam int SD = 4;
  localparam int DN = 3;

  logic        clk, rst_n;
  logic [3:0]  row_i, col_o;
  logic [15:0] mask;
  int          rdy_mode;
  int          checks, errors;
  int          valid_cycles, lost_pulses;

  module_control_teclado_if kif ();

  module_control_teclado #(
    .SCAN_DIV  (SD),
    .DEBOUNCE_N(DN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .row_i(row_i),
    .col_o(col_o),
    .key  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: row r pulled low when its column is driven low and key (r,c) is pressed.
  function automatic logic [3:0] rows_for(input logic [3:0] col, input logic [15:0] m);
    logic [3:0] rows;
    rows = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && m[r*4+c]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row_i = rows_for(col_o, mask);

  // Behavioural model: mode 0 scanning, 1 counting press ticks, 2 key held.
  int         m_div, m_col, m_mode, m_r, m_hits, m_idle, m_code;
  bit         m_valid, m_lost;
  logic [3:0] m_s1, m_s2;

  task automatic model_reset();
    m_div = 0; m_col = 0; m_mode = 0; m_r = 0; m_hits = 0; m_idle = 0; m_code = 0;
    m_valid = 0; m_lost = 0; m_s1 = 4'hf; m_s2 = 4'hf;
  endtask

  task automatic model_step(input bit rdy, input logic [3:0] row_now);
    bit tick, hit, idle, accept;
    int nlow, r;
    tick = (m_div == SD - 1);
    m_div = tick ? 0 : m_div + 1;
    nlow = 0;
    r = 0;
    for (int i = 0; i < 4; i++) if (!m_s2[i]) begin nlow++; r = i; end
    hit = (nlow == 1);
    idle = (nlow == 0);
    accept = 0;
    m_lost = 0;
    if (tick) begin
      if (m_mode == 0) begin
        if (hit) begin
          m_r = r; m_hits = 1;
          if (DN == 1) begin accept = 1; m_mode = 2; m_idle = 0; end
          else m_mode = 1;
        end else m_col = (m_col + 1) % 4;
      end else if (m_mode == 1) begin
        if (hit && r == m_r) begin
          m_hits++;
          if (m_hits == DN) begin accept = 1; m_mode = 2; m_idle = 0; end
        end else begin m_mode = 0; m_col = (m_col + 1) % 4; end
      end else begin
        if (idle) begin
          m_idle++;
          if (m_idle == DN) begin m_mode = 0; m_col = (m_col + 1) % 4; end
        end else m_idle = 0;
      end
    end
    if (m_valid && rdy) m_valid = 0;
    if (accept) begin
      if (m_valid) m_lost = 1;
      else begin m_valid = 1; m_code = m_r * 4 + m_col; end
    end
    m_s2 = m_s1;
    m_s1 = row_now;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_col();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_col);
  endfunction

  task automatic check_outputs();
    chk("col", col_o, model_col());
    chk("code", kif.key_code, m_code);
    chk("valid", kif.key_valid, m_valid);
    chk("pressed", kif.key_pressed, (m_mode == 2));
    chk("lost", kif.key_lost, m_lost);
    if (kif.key_valid) valid_cycles++;
    if (kif.key_lost) lost_pulses++;
  endtask

  // Called at a negedge; each iteration predicts the coming posedge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_outputs();
      if (rdy_mode == 2) kif.key_ready = 1'($urandom_range(0, 1));
      else kif.key_ready = (rdy_mode == 1);
      #1;
      model_step(kif.key_ready, rows_for(model_col(), mask));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_col"}, col_o, 4'b1110);
    chk({tag, "_code"}, kif.key_code, 4'd0);
    chk({tag, "_valid"}, kif.key_valid, 1'b0);
    chk({tag, "_pressed"}, kif.key_pressed, 1'b0);
    chk({tag, "_lost"}, kif.key_lost, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_mode(input int mode, input int bound, input string tag);
    int n;
    n = 0;
    while (m_mode != mode && n < bound) begin run(1); n++; end
    if (n >= bound) chk({tag, "_timeout"}, 0, 1);
  endtask

  int k, sel;

  initial begin
    checks = 0; errors = 0; valid_cycles = 0; lost_pulses = 0;
    rst_n = 1'b0; mask = '0; rdy_mode = 0; kif.key_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Idle sweep
    run(24);
    chk("sweep_no_valid", valid_cycles, 0);

    // Clean press of (2,1) with a ready consumer
    rdy_mode = 1; valid_cycles = 0; mask = 16'h1 << 9;
    run(60);
    chk("press_code", kif.key_code, 4'd9);
    chk("press_held", kif.key_pressed, 1'b1);
    chk("press_col_frozen", col_o, 4'b1101);
    mask = '0;
    run(40);
    chk("press_valid_once", valid_cycles, 1);

    // Bounce on (0,3)
    valid_cycles = 0;
    run_until_mode(0, 8, "bounce_idle");
    for (int b = 0; b < 2; b++) begin
      mask = 16'h1 << 3; run(4);
      mask = '0; run(4);
    end
    run(20);
    chk("bounce_no_valid", valid_cycles, 0);

    // Stalled consumer: (1,0) then (3,3)
    rdy_mode = 0; lost_pulses = 0; mask = 16'h1 << 4;
    run(50);
    mask = '0; run(40);
    mask = 16'h1 << 15; run(80);
    chk("stall_code", kif.key_code, 4'd4);
    chk("stall_valid", kif.key_valid, 1'b1);
    chk("stall_lost_once", lost_pulses, 1);
    rdy_mode = 1; run(1);
    rdy_mode = 0; run(1);
    chk("stall_drained", kif.key_valid, 1'b0);
    mask = '0; run(40);

    // Ghosting on (0,2)+(1,2)
    rdy_mode = 1; valid_cycles = 0;
    mask = (16'h1 << 2) | (16'h1 << 6);
    run(60);
    chk("ghost_no_valid", valid_cycles, 0);
    mask = '0; run(10);

    // Reset during debounce, then during hold with valid high
    mask = 16'h1 << 5;
    run_until_mode(1, 40, "deb_reach");
    mask = '0;
    pulse_reset("rst_deb");
    run(8);
    rdy_mode = 0; mask = 16'h1 << 5;
    run_until_mode(2, 80, "hold_reach");
    run(2);
    chk("hold_valid", kif.key_valid, 1'b1);
    mask = '0;
    pulse_reset("rst_hold");
    run(20);

    // Random traffic
    for (int e = 0; e < 40; e++) begin
      k = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      rdy_mode = $urandom_range(0, 2);
      if (sel == 0) mask = '0;
      else if (sel == 3) mask = (16'h1 << k) | (16'h1 << $urandom_range(0, 15));
      else mask = 16'h1 << k;
      run($urandom_range(1, 60));
    end
    mask = '0; rdy_mode = 1;
    run(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
